// File: rtl/boot_pkg.sv
// State encoding and default sizing shared by the instruction-memory boot loader.
package boot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    HOLD,
    RELEASE,
    RUN,
    HALTED
  } boot_state_t;

  localparam int DEF_HOLD_CYCLES = 2;
  localparam int DEF_MAX_WORDS   = 64;
  localparam int DEF_HALT_CYCLES = 4;

endpackage

// File: rtl/pc_stall_detector.sv
// Counts consecutive enabled cycles with an unchanged PC; stall rises once HALT_CYCLES is reached.
// One cycle from the PC settling to the first count; the counter saturates and clears on any change.
module pc_stall_detector
  import boot_pkg::*;
#(
  parameter int HALT_CYCLES = DEF_HALT_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] pc,
  output logic        stall
);

  localparam int CW = $clog2(HALT_CYCLES + 1);

  logic [31:0]   pc_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= '0;
      cnt  <= '0;
    end else begin
      pc_q <= pc;
      if (!en || (pc != pc_q)) begin
        cnt <= '0;
      end else if (cnt != CW'(HALT_CYCLES)) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign stall = en && (cnt == CW'(HALT_CYCLES));

endmodule

// File: rtl/imem_boot_loader.sv
// Boot sequencer: streams a program into CPU instruction memory while holding the CPU in reset.
// Define BOOT_HALT_DETECT_EN to move RUN -> HALTED when the CPU PC stops changing.
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int MAX_WORDS   = DEF_MAX_WORDS,
  parameter int HALT_CYCLES = DEF_HALT_CYCLES,
  localparam int CW = $clog2(MAX_WORDS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [31:0]   load_data,
  input  logic [31:0]   load_addr,
  input  logic          load_last,
  output logic          initialize,
  output logic [31:0]   instruction_initialize_data,
  output logic [31:0]   instruction_initialize_address,
  output logic          cpu_rst,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [CW-1:0] word_count,
  input  logic [31:0]   cpu_pc,
  output logic          halted
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  boot_state_t   state_q, state_d;
  logic [HW-1:0] hold_q;
  logic          last_q, mis_q, mis_d;
  logic          hs, hold_end, start_acc, stall;

`ifdef BOOT_HALT_DETECT_EN
  pc_stall_detector #(
    .HALT_CYCLES(HALT_CYCLES)
  ) u_stall (
    .clk  (clk),
    .rst  (rst),
    .en   (state_q == RUN),
    .pc   (cpu_pc),
    .stall(stall)
  );
`else
  logic unused_pc;
  assign stall     = 1'b0;
  assign unused_pc = (^cpu_pc) ^ (HALT_CYCLES > 0);
`endif

  always_comb begin
    state_d   = state_q;
    hs        = load_ready && load_valid;
    hold_end  = (state_q == HOLD) && (hold_q == HW'(HOLD_CYCLES - 1));
    start_acc = start && (state_q inside {IDLE, RUN, HALTED});
    // A misaligned word is counted but kept off the bus for its whole HOLD.
    mis_d     = hs ? (load_addr[1:0] != 2'b00) : mis_q;
    case (state_q)
      IDLE, HALTED: if (start) state_d = ACCEPT;
      ACCEPT:       if (hs) state_d = HOLD;
      HOLD: begin
        if (hold_end) begin
          state_d = (last_q || (word_count == CW'(MAX_WORDS))) ? RELEASE : ACCEPT;
        end
      end
      RELEASE:      state_d = RUN;
      RUN: begin
        if (start) state_d = ACCEPT;
        else if (stall) state_d = HALTED;
      end
      default:      state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q                        <= IDLE;
      hold_q                         <= '0;
      last_q                         <= 1'b0;
      mis_q                          <= 1'b0;
      load_ready                     <= 1'b0;
      initialize                     <= 1'b0;
      cpu_rst                        <= 1'b1;
      busy                           <= 1'b0;
      done                           <= 1'b0;
      halted                         <= 1'b0;
      error                          <= 1'b0;
      word_count                     <= '0;
      instruction_initialize_data    <= '0;
      instruction_initialize_address <= '0;
    end else begin
      state_q    <= state_d;
      mis_q      <= mis_d;
      // Outputs are decoded from the next state so they line up with state_q.
      load_ready <= (state_d == ACCEPT);
      initialize <= (state_d == ACCEPT) || ((state_d == HOLD) && !mis_d);
      cpu_rst    <= (state_d != RUN);
      busy       <= (state_d inside {ACCEPT, HOLD, RELEASE});
      done       <= (state_d == RUN);
      halted     <= (state_d == HALTED);

      if (start_acc) begin
        word_count <= '0;
        error      <= 1'b0;
      end

      if (hs) begin
        word_count <= word_count + 1'b1;
        last_q     <= load_last;
        hold_q     <= '0;
        if (mis_d) begin
          error <= 1'b1;
        end else begin
          instruction_initialize_data    <= load_data;
          instruction_initialize_address <= load_addr;
        end
      end else if (state_q == HOLD) begin
        hold_q <= hold_q + 1'b1;
      end

      if (hold_end && !last_q && (word_count == CW'(MAX_WORDS))) begin
        error <= 1'b1;
      end
    end
  end

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Boot sequencer for the single-cycle `cpu`: accepts a program as a word stream and writes it into instruction memory through the CPU's initialize port. While writing, it holds the CPU in reset; when the program is complete, it releases reset. This block replaces hand-timed testbench loading with a deterministic FSM and sits between a program source (bench, UART, ROM walker) and `cpu`.

## Interface
Parameters:
- `HOLD_CYCLES`, 2: cycles each word is held on the initialize bus (≥1).
- `MAX_WORDS`, 64: program length limit; `word_count` width is `$clog2(MAX_WORDS+1)`.
- `HALT_CYCLES`, 4: consecutive unchanged-PC cycles that declare a halt (`BOOT_HALT_DETECT_EN` only).

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins or restarts loading.
- `load_valid` in 1: source word valid.
- `load_ready` out 1: loader accepts a word this cycle.
- `load_data` in 32: instruction word.
- `load_addr` in 32: byte address; must be word-aligned.
- `load_last` in 1: marks the final word.
- `initialize` out 1: drives `cpu.initialize`.
- `instruction_initialize_data` out 32: drives the matching CPU port.
- `instruction_initialize_address` out 32: drives the matching CPU port.
- `cpu_rst` out 1: drives `cpu.rst`.
- `busy` out 1: high in ACCEPT, HOLD and RELEASE.
- `done` out 1: high in RUN.
- `error` out 1: sticky; set on a misaligned address or overflow.
- `word_count` out clog2(MAX_WORDS+1): number of words accepted.
- `cpu_pc` in 32: CPU program counter; observed only with the macro.
- `halted` out 1: high in HALTED.

## Operation
- States: IDLE, ACCEPT, HOLD, RELEASE, RUN, HALTED.
- IDLE: `initialize`=0, `cpu_rst`=1. `start` → ACCEPT; clears `word_count` and `error`.
- ACCEPT: `load_ready`=1, `initialize`=1. The bus keeps the previous word, so the rewrite is harmless. On `load_valid&&load_ready`:
  - latch data, address and last;
  - increment `word_count`;
  - go to HOLD.
- HOLD: `load_ready`=0, `initialize`=1, bus drives the latched word for exactly HOLD_CYCLES cycles. Exit to RELEASE if the latched last flag is set or `word_count`==MAX_WORDS; otherwise back to ACCEPT.
- Overflow: reaching MAX_WORDS without `load_last` sets `error` and the block proceeds to RELEASE.
- Misaligned address (`load_addr[1:0]`≠0): the word is accepted and counted but not driven. `initialize`=0 during its HOLD, and `error` is set.
- RELEASE: one cycle with `initialize`=0, `cpu_rst`=1, then RUN.
- RUN: `cpu_rst`=0, `done`=1. `start` → ACCEPT with `cpu_rst` reasserted in the same cycle (reload).
- HALTED: `cpu_rst`=1, `halted`=1. `start` → ACCEPT.
- `start` is ignored in ACCEPT, HOLD and RELEASE.
- Address and data are passed through unmodified; no increment logic.

## Timing
- Reset values:
  - state IDLE;
  - `cpu_rst`=1;
  - `initialize`=0, `load_ready`=0;
  - `busy`/`done`/`halted`/`error`=0;
  - data, address and `word_count`=0.
- `rst` mid-operation returns the block to IDLE next edge; the partial program is abandoned.
- `start` at edge N → `load_ready`=1 from N+1.
- Handshake at edge N → bus valid from N+1 through N+HOLD_CYCLES; `load_ready` returns at N+HOLD_CYCLES+1.
- Per-word cost: HOLD_CYCLES+1 cycles.
- Last-word handshake at edge N → RELEASE at N+HOLD_CYCLES+1; `cpu_rst`=0 from N+HOLD_CYCLES+2.
- All outputs are registered.

## Configuration
- `BOOT_HALT_DETECT_EN` defined:
  - in RUN, compare `cpu_pc` against its registered value;
  - count consecutive equal cycles;
  - reaching HALT_CYCLES → HALTED next edge. This catches the BEQ R0,R0,-1 terminator.
  - Any PC change clears the counter.
- Not defined: `cpu_pc` is ignored, `halted` is tied 0, HALTED is unreachable.

## Structure
- Package `boot_pkg`: state enum `boot_state_t` and default constants for HOLD_CYCLES, MAX_WORDS and HALT_CYCLES.
- Sub-module `pc_stall_detector` (PC register, compare, saturating counter, `stall` output), instantiated only under `BOOT_HALT_DETECT_EN`.

## Test plan
- Reset then idle: all outputs at reset values; `cpu_rst`=1; `load_ready`=0 for 10 cycles.
- Load ADD 0x00020820@0, SUB 0x00844022@4 (last), HOLD_CYCLES=2 → each word on the bus exactly 2 cycles. `word_count`=2, `cpu_rst` falls 4 cycles after the last handshake, `done`=1.
- Gap addresses 32 then 40 with `load_valid` stalled 5 cycles between words → `load_ready` stays high through the stall; address 40 is driven verbatim.
- Misaligned `load_addr`=0x6 → `initialize`=0 during that HOLD; `error`=1 persists into RUN.
- MAX_WORDS=4, six words with no `load_last` → 4 accepted, `error`=1, RUN; words 5-6 never get ready.
- Macro on: BEQ -1 at 72, `cpu_pc` fixed at 72 → `halted`=1 and `cpu_rst`=1 after HALT_CYCLES=4. `rst` asserted mid-HOLD → IDLE next edge.
